// File: rtl/pc_unit.sv
// pc_unit: program counter with optional return-address stack.
// Build option: define PC_UNIT_RAS_EN to include the RAS (default: omitted).
//
// Ports:
//   CLK          clock, all state changes on the falling edge
//   RESET_N      asynchronous active-low reset
//   stall        hold PC and RAS
//   branchTaken  redirect to branchTarget
//   branchTarget branch/call destination
//   excReq       exception redirect (beats stall)
//   excVector    exception handler address
//   call         push pcPlus, jump to branchTarget
//   ret          pop RAS top as next PC
//   pcOut        current PC (registered)
//   pcPlus       pcOut + STEP (combinational, wraps)
//   redirect     high one cycle after a non-sequential load
//   rasEmpty     RAS count == 0
//   rasFull      RAS count == RAS_DEPTH
module pc_unit #(
  parameter int              BITS      = 32,
  parameter logic [BITS-1:0] RST_VEC   = '0,
  parameter int              STEP      = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            stall,
  input  logic            branchTaken,
  input  logic [BITS-1:0] branchTarget,
  input  logic            excReq,
  input  logic [BITS-1:0] excVector,
  input  logic            call,
  input  logic            ret,
  output logic [BITS-1:0] pcOut,
  output logic [BITS-1:0] pcPlus,
  output logic            redirect,
  output logic            rasEmpty,
  output logic            rasFull
);

  localparam logic [BITS-1:0] STEP_V = BITS'(STEP);

  logic [BITS-1:0] r_pc;
  logic            r_redir;
  logic [BITS-1:0] w_next;
  logic            w_redir;

  assign pcOut    = r_pc;
  assign redirect = r_redir;
  assign pcPlus   = r_pc + STEP_V;

`ifdef PC_UNIT_RAS_EN

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(RAS_DEPTH);

  logic [BITS-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]   r_top;
  logic [CW-1:0]   r_cnt;

  logic          w_empty;
  logic          w_full;
  logic [PW-1:0] w_top_idx;
  logic          w_push;
  logic          w_pop;
  logic          w_clr;

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == FULL_C);
  assign w_top_idx = r_top - PW'(1);
  assign rasEmpty  = w_empty;
  assign rasFull   = w_full;

  always_comb begin
    w_next  = r_pc;
    w_redir = 1'b0;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_clr   = 1'b0;
    if (excReq) begin
      w_next  = excVector;
      w_redir = 1'b1;
      w_clr   = 1'b1;
    end else if (stall) begin
      w_next  = r_pc;
    end else if (ret && !w_empty) begin
      w_next  = r_ras[w_top_idx];
      w_redir = 1'b1;
      w_pop   = 1'b1;
    end else if (call) begin
      w_next  = branchTarget;
      w_redir = 1'b1;
      w_push  = 1'b1;
    end else if (branchTaken) begin
      w_next  = branchTarget;
      w_redir = 1'b1;
    end else begin
      w_next  = pcPlus;
    end
  end

  // Circular buffer: a push while full lands on the oldest slot.
  always_ff @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_top <= '0;
      r_cnt <= '0;
    end else if (w_clr) begin
      r_cnt <= '0;
    end else if (w_push) begin
      r_top <= r_top + PW'(1);
      if (!w_full)
        r_cnt <= r_cnt + CW'(1);
    end else if (w_pop) begin
      r_top <= w_top_idx;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Entries are not reset; only the count is meaningful.
  always_ff @(negedge CLK) begin
    if (RESET_N && w_push)
      r_ras[r_top] <= pcPlus;
  end

`else

  logic w_unused;
  assign w_unused = ret;
  assign rasEmpty = 1'b1;
  assign rasFull  = 1'b0;

  always_comb begin
    w_next  = r_pc;
    w_redir = 1'b0;
    if (excReq) begin
      w_next  = excVector;
      w_redir = 1'b1;
    end else if (stall) begin
      w_next  = r_pc;
    end else if (call || branchTaken) begin
      w_next  = branchTarget;
      w_redir = 1'b1;
    end else begin
      w_next  = pcPlus;
    end
  end

`endif

  always_ff @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pc    <= RST_VEC;
      r_redir <= 1'b0;
    end else begin
      r_pc    <= w_next;
      r_redir <= w_redir;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit.
// Covers both builds, selected by PC_UNIT_RAS_EN.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br, call, ret, exc;
  logic [31:0] tgt, vec;
  logic [31:0] pc, pcp;
  logic        redir, emp, full;

  logic        rst8_n, br8;
  logic [7:0]  tgt8;
  logic        z8;
  logic [7:0]  zv8;
  logic [7:0]  pc8, pcp8;
  logic        redir8, emp8, full8;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_unit #(
    .BITS(32), .RST_VEC(32'h100),
    .STEP(4), .RAS_DEPTH(4)
  ) u_dut (
    .CLK(clk), .RESET_N(rst_n),
    .stall(stall), .branchTaken(br),
    .branchTarget(tgt), .excReq(exc),
    .excVector(vec), .call(call),
    .ret(ret), .pcOut(pc),
    .pcPlus(pcp), .redirect(redir),
    .rasEmpty(emp), .rasFull(full)
  );

  pc_unit #(
    .BITS(8), .RST_VEC(8'h10),
    .STEP(4), .RAS_DEPTH(2)
  ) u_dut8 (
    .CLK(clk), .RESET_N(rst8_n),
    .stall(z8), .branchTaken(br8),
    .branchTarget(tgt8), .excReq(z8),
    .excVector(zv8), .call(z8),
    .ret(z8), .pcOut(pc8),
    .pcPlus(pcp8), .redirect(redir8),
    .rasEmpty(emp8), .rasFull(full8)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; br = 0; call = 0;
    ret = 0; exc = 0;
  endtask

  initial begin
    rst_n = 0; rst8_n = 0;
    idle();
    tgt = 0; vec = 0;
    br8 = 0; tgt8 = 0; z8 = 0; zv8 = 0;

    #12;
    check("rst_pc", pc, 32'h100);
    check("rst_redir", {31'b0, redir}, 0);
    check("rst_empty", {31'b0, emp}, 1);
    check("rst_full", {31'b0, full}, 0);
    check("rst8_pc", {24'b0, pc8}, 32'h10);
    #1 rst_n = 1; rst8_n = 1;
    #1;
    check("free0", pc, 32'h100);
    check("pcplus0", pcp, 32'h104);
    cyc(); check("free1", pc, 32'h104);
    cyc(); check("free2", pc, 32'h108);
    cyc(); check("free3", pc, 32'h10C);
    check("free_redir", {31'b0, redir}, 0);

    br = 1; tgt = 32'h40;
    cyc(); check("br_pc", pc, 32'h40);
    check("br_redir", {31'b0, redir}, 1);
    stall = 1; tgt = 32'h200;
    cyc(); check("stall_pc", pc, 32'h40);
    check("stall_redir", {31'b0, redir}, 0);
    exc = 1; vec = 32'h80;
    cyc(); check("exc_pc", pc, 32'h80);
    check("exc_redir", {31'b0, redir}, 1);
    check("exc_empty", {31'b0, emp}, 1);
    idle();
    cyc(); check("exc_seq", pc, 32'h84);
    check("seq_redir", {31'b0, redir}, 0);

    br = 1; tgt = 32'h10;
    cyc(); check("to10", pc, 32'h10);
    br = 0;

`ifdef PC_UNIT_RAS_EN
    call = 1; tgt = 32'h300;
    cyc(); check("call1", pc, 32'h300);
    check("call1_ne", {31'b0, emp}, 0);
    tgt = 32'h500;
    cyc(); check("call2", pc, 32'h500);
    call = 0; ret = 1;
    cyc(); check("ret1", pc, 32'h304);
    check("ret1_redir", {31'b0, redir}, 1);
    cyc(); check("ret2", pc, 32'h14);
    check("ret2_empty", {31'b0, emp}, 1);
    ret = 0;

    br = 1; tgt = 32'h800;
    cyc(); br = 0;
    call = 1;
    tgt = 32'h1000; cyc();
    tgt = 32'h2000; cyc();
    tgt = 32'h3000; cyc();
    tgt = 32'h4000; cyc();
    check("full4", {31'b0, full}, 1);
    tgt = 32'h5000; cyc();
    check("call5", pc, 32'h5000);
    check("full5", {31'b0, full}, 1);
    call = 0; ret = 1;
    cyc(); check("pop1", pc, 32'h4004);
    check("pop1_nf", {31'b0, full}, 0);
    cyc(); check("pop2", pc, 32'h3004);
    cyc(); check("pop3", pc, 32'h2004);
    cyc(); check("pop4", pc, 32'h1004);
    check("pop4_empty", {31'b0, emp}, 1);
    cyc(); check("pop5_seq", pc, 32'h1008);
    check("pop5_redir", {31'b0, redir}, 0);

    ret = 0; call = 1; tgt = 32'h600;
    cyc(); check("cr_push", pc, 32'h600);
    ret = 1; tgt = 32'h900;
    cyc(); check("cr_pop", pc, 32'h100C);
    check("cr_empty", {31'b0, emp}, 1);
    ret = 0; call = 1; tgt = 32'hA00;
    cyc();
    call = 0; exc = 1; vec = 32'hC0;
    cyc(); check("exc_clr", {31'b0, emp}, 1);
    exc = 0; ret = 1;
    cyc(); check("exc_noret", pc, 32'hC4);
    ret = 0;
`else
    call = 1; tgt = 32'h300;
    cyc(); check("nr_call", pc, 32'h300);
    check("nr_redir", {31'b0, redir}, 1);
    check("nr_empty1", {31'b0, emp}, 1);
    call = 0; ret = 1;
    cyc(); check("nr_ret", pc, 32'h304);
    check("nr_ret_redir", {31'b0, redir}, 0);
    check("nr_empty2", {31'b0, emp}, 1);
    check("nr_full", {31'b0, full}, 0);
    ret = 0;
`endif

    br8 = 1; tgt8 = 8'hFC;
    cyc(); check("b8_pc", {24'b0, pc8}, 32'hFC);
    check("b8_plus", {24'b0, pcp8}, 32'h00);
    br8 = 0;
    cyc(); check("b8_wrap", {24'b0, pc8}, 32'h00);
    #2 rst8_n = 0;
    #1;
    check("b8_arst", {24'b0, pc8}, 32'h10);
    check("b8_arst_rd", {31'b0, redir8}, 0);
    @(posedge clk); #1 rst8_n = 1;
    cyc(); check("b8_resume", {24'b0, pc8}, 32'h14);

    idle();
    call = 1; tgt = 32'h700;
    #2 rst_n = 0;
    #1;
    check("mid_rst_pc", pc, 32'h100);
    check("mid_rst_empty", {31'b0, emp}, 1);
    @(posedge clk); #1;
    call = 0; rst_n = 1;
    #1 check("post_rst", pc, 32'h100);
    cyc(); check("post_seq", pc, 32'h104);
    check("post_redir", {31'b0, redir}, 0);
    check("post_empty", {31'b0, emp}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
